// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous byte-enable dual-port RAM.
package ram_pkg;

   typedef enum logic {
      RDW_READ_FIRST,
      RDW_WRITE_FIRST
   } rdw_mode_t;

   // Widest word be_merge can handle; callers cast to and from it.
   localparam int MAX_W = 1024;
   localparam int MAX_B = MAX_W / 8;

   function automatic int byte_cnt(input int w);
      return w / 8;
   endfunction

   function automatic logic [MAX_W-1:0] be_merge(
      input logic [MAX_W-1:0] old_w,
      input logic [MAX_W-1:0] new_w,
      input logic [MAX_B-1:0] be
   );
      logic [MAX_W-1:0] r;
      r = old_w;
      for (int i = 0; i < MAX_B; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read return pipeline: delays {valid, err, data} by RD_LAT cycles.
module ram_rd_pipe #(
   parameter int WIDTH  = 32,
   parameter int RD_LAT = 1
) (
   input  logic             clock,
   input  logic             nreset,
   input  logic             push_valid,
   input  logic             push_err,
   input  logic [WIDTH-1:0] push_data,
   output logic             rvalid,
   output logic             err,
   output logic [WIDTH-1:0] rdata
);

   logic [RD_LAT-1:0] vld;
   logic [RD_LAT-1:0] erq;
   logic [WIDTH-1:0]  dat [RD_LAT];

   // Data only moves with a valid beat, so rdata holds between reads.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         vld <= '0;
         erq <= '0;
         for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
      end else begin
         vld[0] <= push_valid;
         erq[0] <= push_err;
         if (push_valid) dat[0] <= push_data;
         for (int i = 1; i < RD_LAT; i++) begin
            vld[i] <= vld[i-1];
            erq[i] <= erq[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end

   assign rvalid = vld[RD_LAT-1];
   assign err    = erq[RD_LAT-1];
   assign rdata  = dat[RD_LAT-1];

endmodule

// File: rtl/dpram_sync_be.sv
// Synchronous true dual-port word RAM with byte enables, pipelined reads,
// configurable read-during-write, write-collision priority and range errors.
module dpram_sync_be
   import ram_pkg::*;
#(
   parameter int        WIDTH    = 32,
   parameter int        DEPTH    = 2048,
   parameter int        ADDR_W   = 32,
   parameter int        RD_LAT   = 1,
   parameter rdw_mode_t RDW_MODE = RDW_READ_FIRST,
   parameter int        WR_PRIO  = 0
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [WIDTH/8-1:0]    a_be,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [WIDTH-1:0]      a_wdata,
   output logic [WIDTH-1:0]      a_rdata,
   output logic                  a_rvalid,
   output logic                  a_err,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [WIDTH/8-1:0]    b_be,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic [WIDTH-1:0]      b_wdata,
   output logic [WIDTH-1:0]      b_rdata,
   output logic                  b_rvalid,
   output logic                  b_err,
   output logic                  collision
);

   localparam int NB = byte_cnt(WIDTH);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

   if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
      $error("dpram_sync_be: RD_LAT must be 1 or 2");
   end
   if ((WIDTH % 8) != 0 || WIDTH > MAX_W) begin : g_bad_width
      $error("dpram_sync_be: WIDTH must be a multiple of 8");
   end
   if ($clog2(DEPTH) > ADDR_W) begin : g_bad_depth
      $error("dpram_sync_be: DEPTH does not fit in ADDR_W");
   end

   logic [WIDTH-1:0] mem [DEPTH];

   logic          a_in;
   logic          b_in;
   logic          a_wr;
   logic          b_wr;
   logic          same;
   logic          coll_now;
   logic [IW-1:0] a_idx;
   logic [IW-1:0] b_idx;

   logic [WIDTH-1:0] a_old;
   logic [WIDTH-1:0] b_old;
   logic [WIDTH-1:0] a_new;
   logic [WIDTH-1:0] b_new;
   logic [WIDTH-1:0] both;
   logic [WIDTH-1:0] a_word;
   logic [WIDTH-1:0] b_word;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   // Range check at full address width before the index is narrowed.
   assign a_in  = ({1'b0, a_addr} < LIMIT);
   assign b_in  = ({1'b0, b_addr} < LIMIT);
   assign a_idx = a_addr[IW-1:0];
   assign b_idx = b_addr[IW-1:0];
   assign a_wr  = a_req & a_we & a_in;
   assign b_wr  = b_req & b_we & b_in;
   assign same  = (a_idx == b_idx);

   assign coll_now = a_wr & b_wr & same;

   always_comb begin
      a_old = mem[a_idx];
      b_old = mem[b_idx];
      a_new = WIDTH'(be_merge(MAX_W'(a_old), MAX_W'(a_wdata), MAX_B'(a_be)));
      b_new = WIDTH'(be_merge(MAX_W'(b_old), MAX_W'(b_wdata), MAX_B'(b_be)));
   end

   // On a collision the priority port is merged last so its bytes win.
   always_comb begin
      both = '0;
      if (WR_PRIO == 0) begin
         both = WIDTH'(be_merge(MAX_W'(b_new), MAX_W'(a_wdata),
                                MAX_B'(a_be)));
      end else begin
         both = WIDTH'(be_merge(MAX_W'(a_new), MAX_W'(b_wdata),
                                MAX_B'(b_be)));
      end
      a_word = coll_now ? both : a_new;
      b_word = coll_now ? both : b_new;
   end

   always_comb begin
      a_q = a_old;
      b_q = b_old;
      if (RDW_MODE == RDW_WRITE_FIRST) begin
         if (b_wr && same) a_q = b_new;
         if (a_wr && same) b_q = a_new;
      end
      if (!a_in) a_q = '0;
      if (!b_in) b_q = '0;
   end

   always_ff @(posedge clock) begin
      if (a_wr) mem[a_idx] <= a_word;
      if (b_wr) mem[b_idx] <= b_word;
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) collision <= 1'b0;
      else         collision <= coll_now;
   end

   ram_rd_pipe #(
      .WIDTH (WIDTH),
      .RD_LAT(RD_LAT)
   ) u_pipe_a (
      .clock     (clock),
      .nreset    (nreset),
      .push_valid(a_req & ~a_we),
      .push_err  (a_req & ~a_in),
      .push_data (a_q),
      .rvalid    (a_rvalid),
      .err       (a_err),
      .rdata     (a_rdata)
   );

   ram_rd_pipe #(
      .WIDTH (WIDTH),
      .RD_LAT(RD_LAT)
   ) u_pipe_b (
      .clock     (clock),
      .nreset    (nreset),
      .push_valid(b_req & ~b_we),
      .push_err  (b_req & ~b_in),
      .push_data (b_q),
      .rvalid    (b_rvalid),
      .err       (b_err),
      .rdata     (b_rdata)
   );

   logic unused_nb;
   assign unused_nb = (NB == 0);

endmodule

// File: tb/tb_dpram_sync_be.sv
// Bench for dpram_sync_be: two configurations driven in parallel and
// checked against a word-level memory model plus directed vectors.
module tb_dpram_sync_be;
   import ram_pkg::*;

   logic clock = 1'b0;
   logic nreset;
   always #5 clock = ~clock;

   logic [1:0]        req;
   logic [1:0]        we;
   logic [1:0][3:0]   be;
   logic [1:0][31:0]  addr;
   logic [1:0][31:0]  wd;

   logic [1:0][1:0][31:0] rdat;
   logic [1:0][1:0]       rv;
   logic [1:0][1:0]       er;
   logic [1:0]            co;

   // Instance 0: RD_LAT 1, read-first, port A priority.
   dpram_sync_be #(
      .RD_LAT(1), .RDW_MODE(RDW_READ_FIRST), .WR_PRIO(0)
   ) u0 (
      .clock(clock), .nreset(nreset),
      .a_req(req[0]), .a_we(we[0]), .a_be(be[0]), .a_addr(addr[0]),
      .a_wdata(wd[0]), .a_rdata(rdat[0][0]), .a_rvalid(rv[0][0]),
      .a_err(er[0][0]),
      .b_req(req[1]), .b_we(we[1]), .b_be(be[1]), .b_addr(addr[1]),
      .b_wdata(wd[1]), .b_rdata(rdat[0][1]), .b_rvalid(rv[0][1]),
      .b_err(er[0][1]),
      .collision(co[0])
   );

   // Instance 1: RD_LAT 2, write-first, port B priority.
   dpram_sync_be #(
      .RD_LAT(2), .RDW_MODE(RDW_WRITE_FIRST), .WR_PRIO(1)
   ) u1 (
      .clock(clock), .nreset(nreset),
      .a_req(req[0]), .a_we(we[0]), .a_be(be[0]), .a_addr(addr[0]),
      .a_wdata(wd[0]), .a_rdata(rdat[1][0]), .a_rvalid(rv[1][0]),
      .a_err(er[1][0]),
      .b_req(req[1]), .b_we(we[1]), .b_be(be[1]), .b_addr(addr[1]),
      .b_wdata(wd[1]), .b_rdata(rdat[1][1]), .b_rvalid(rv[1][1]),
      .b_err(er[1][1]),
      .collision(co[1])
   );

   typedef struct packed {
      logic        v;
      logic        e;
      logic [31:0] d;
   } resp_t;

   logic [31:0] mm     [2][2048];
   resp_t       hist   [2][2][2];
   logic [31:0] last_d [2][2];
   logic        colx   [2];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] put(input logic [31:0] w,
                                       input logic [31:0] nd,
                                       input logic [3:0]  b);
      logic [31:0] r;
      r = w;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nd[8*i +: 8];
      return r;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         colx[d] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            last_d[d][p] = '0;
            hist[d][p][0] = '0;
            hist[d][p][1] = '0;
         end
      end
   endtask

   // One clock: predict from current inputs, clock, then compare.
   task automatic step();
      logic        ok  [2];
      logic [31:0] pre [2];
      resp_t       cur;
      resp_t       r;
      if (nreset) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               ok[p]  = req[p] && (addr[p] < 32'd2048);
               pre[p] = ok[p] ? mm[d][addr[p][10:0]] : 32'h0;
            end
            // lower-priority port first, so the priority port lands last
            for (int k = 0; k < 2; k++) begin
               int p;
               p = (k == 0) ? 1 - d : d;
               if (ok[p] && we[p])
                  mm[d][addr[p][10:0]] =
                     put(mm[d][addr[p][10:0]], wd[p], be[p]);
            end
            colx[d] = ok[0] && ok[1] && we[0] && we[1] &&
                      (addr[0] == addr[1]);
            for (int p = 0; p < 2; p++) begin
               cur.v = req[p] && !we[p];
               cur.e = req[p] && !ok[p];
               if (!ok[p])      cur.d = '0;
               else if (d == 1) cur.d = mm[d][addr[p][10:0]];
               else             cur.d = pre[p];
               hist[d][p][1] = hist[d][p][0];
               hist[d][p][0] = cur;
            end
         end
      end
      @(posedge clock);
      #1;
      if (!nreset) begin
         model_clear();
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d collision", d), 32'(co[d]), 0);
            for (int p = 0; p < 2; p++) begin
               chk($sformatf("rst d%0d p%0d rvalid", d, p), 32'(rv[d][p]), 0);
               chk($sformatf("rst d%0d p%0d err", d, p), 32'(er[d][p]), 0);
               chk($sformatf("rst d%0d p%0d rdata", d, p), rdat[d][p], 0);
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d collision", d), 32'(co[d]), 32'(colx[d]));
            for (int p = 0; p < 2; p++) begin
               r = (d == 0) ? hist[d][p][0] : hist[d][p][1];
               if (r.v) last_d[d][p] = r.d;
               chk($sformatf("d%0d p%0d rvalid", d, p), 32'(rv[d][p]), 32'(r.v));
               chk($sformatf("d%0d p%0d err", d, p), 32'(er[d][p]), 32'(r.e));
               chk($sformatf("d%0d p%0d rdata", d, p), rdat[d][p],
                   last_d[d][p]);
            end
         end
      end
   endtask

   task automatic idle();
      req = '0;
      we  = '0;
      be  = '0;
   endtask

   typedef struct {
      logic [1:0]       req;
      logic [1:0]       we;
      logic [1:0][3:0]  be;
      logic [1:0][31:0] addr;
      logic [1:0][31:0] wd;
      logic [31:0]      xa;
      logic [31:0]      xb;
      logic             xav;
      logic             xae;
      logic             xbv;
      logic             xbe;
      logic             xc;
   } vec_t;

   function automatic vec_t row(
      input logic ar, input logic aw, input logic [3:0] ab,
      input logic [31:0] aa, input logic [31:0] ad,
      input logic br, input logic bw, input logic [3:0] bb,
      input logic [31:0] ba, input logic [31:0] bd,
      input logic [31:0] xa, input logic [31:0] xb,
      input logic xav, input logic xae, input logic xbv,
      input logic xbe, input logic xc);
      vec_t v;
      v.req = {br, ar};
      v.we  = {bw, aw};
      v.be[0] = ab;  v.be[1] = bb;
      v.addr[0] = aa; v.addr[1] = ba;
      v.wd[0] = ad;  v.wd[1] = bd;
      v.xa = xa;  v.xb = xb;
      v.xav = xav; v.xae = xae;
      v.xbv = xbv; v.xbe = xbe;
      v.xc = xc;
      return v;
   endfunction

   vec_t tv [11];

   initial begin
      // Expected values for instance 0, sampled right after each row's edge.
      tv[0]  = row(1,1,4'hF,5,32'h11223344, 1,1,4'hF,9,0,
                   0,0, 0,0,0,0,0);
      tv[1]  = row(1,0,4'h0,5,0, 1,1,4'hF,3,0,
                   32'h11223344,0, 1,0,0,0,0);
      tv[2]  = row(1,1,4'hF,0,32'h12345678, 1,1,4'h5,5,32'hAABBCCDD,
                   32'h11223344,0, 0,0,0,0,0);
      tv[3]  = row(1,0,4'h0,5,0, 0,0,4'h0,0,0,
                   32'h11BB33DD,0, 1,0,0,0,0);
      tv[4]  = row(1,1,4'hF,9,32'hDEADBEEF, 1,0,4'h0,9,0,
                   32'h11BB33DD,0, 0,0,1,0,0);
      tv[5]  = row(1,1,4'hC,3,32'hFFFFFFFF, 1,1,4'h6,3,0,
                   32'h11BB33DD,0, 0,0,0,0,1);
      tv[6]  = row(1,0,4'h0,3,0, 0,0,4'h0,0,0,
                   32'hFFFF0000,0, 1,0,0,0,0);
      tv[7]  = row(1,0,4'h0,2048,0, 0,0,4'h0,0,0,
                   0,0, 1,1,0,0,0);
      tv[8]  = row(1,1,4'hF,4096,32'hCAFEF00D, 0,0,4'h0,0,0,
                   0,0, 0,1,0,0,0);
      tv[9]  = row(1,0,4'h0,0,0, 0,0,4'h0,0,0,
                   32'h12345678,0, 1,0,0,0,0);
      tv[10] = row(0,0,4'h0,0,0, 0,0,4'h0,0,0,
                   32'h12345678,0, 0,0,0,0,0);

      addr = '0;
      wd   = '0;
      idle();
      nreset = 1'b0;
      model_clear();
      repeat (3) step();
      nreset = 1'b1;

      for (int i = 0; i < 32; i += 2) begin
         req = 2'b11;
         we  = 2'b11;
         be[0] = 4'hF;
         be[1] = 4'hF;
         addr[0] = 32'(i);
         addr[1] = 32'(i + 1);
         wd[0] = 32'(i) * 32'h01030507 ^ 32'h5A5A0000;
         wd[1] = 32'(i + 1) * 32'h01030507 ^ 32'h5A5A0000;
         step();
      end
      idle();
      step();

      for (int i = 0; i < 11; i++) begin
         req  = tv[i].req;
         we   = tv[i].we;
         be   = tv[i].be;
         addr = tv[i].addr;
         wd   = tv[i].wd;
         step();
         chk($sformatf("vec%0d a_rdata", i), rdat[0][0], tv[i].xa);
         chk($sformatf("vec%0d a_rvalid", i), 32'(rv[0][0]), 32'(tv[i].xav));
         chk($sformatf("vec%0d a_err", i), 32'(er[0][0]), 32'(tv[i].xae));
         chk($sformatf("vec%0d b_rdata", i), rdat[0][1], tv[i].xb);
         chk($sformatf("vec%0d b_rvalid", i), 32'(rv[0][1]), 32'(tv[i].xbv));
         chk($sformatf("vec%0d b_err", i), 32'(er[0][1]), 32'(tv[i].xbe));
         chk($sformatf("vec%0d collision", i), 32'(co[0]), 32'(tv[i].xc));
         if (i == 5) chk("wf b_rdata", rdat[1][1], 32'hDEADBEEF);
         if (i == 7) chk("prio1 a_rdata", rdat[1][0], 32'hFF000000);
      end

      // RD_LAT 2 back-to-back burst on port B.
      idle();
      for (int k = 0; k < 6; k++) begin
         req[1]  = (k < 4);
         we[1]   = 1'b0;
         addr[1] = 32'(k);
         step();
         chk($sformatf("lat2 burst k%0d", k), 32'(rv[1][1]),
             32'((k >= 1) && (k <= 4)));
      end

      // Reset lands while two reads are in flight.
      for (int k = 0; k < 2; k++) begin
         req[1]  = 1'b1;
         addr[1] = 32'(k);
         step();
      end
      chk("pre-reset rvalid", 32'(rv[1][1]), 1);
      idle();
      nreset = 1'b0;
      #1;
      chk("async rst rvalid", 32'(rv[1][1]), 0);
      chk("async rst rdata", rdat[1][1], 0);
      model_clear();
      repeat (2) step();
      nreset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("post rst rvalid k%0d", k), 32'(rv[1][1]), 0);
      end

      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            int unsigned sel;
            req[p] = ($urandom_range(0, 4) != 0);
            we[p]  = 1'($urandom_range(0, 1));
            be[p]  = 4'($urandom);
            wd[p]  = $urandom;
            sel    = $urandom_range(0, 15);
            if (sel == 0)      addr[p] = 32'd2048 + $urandom_range(0, 3);
            else if (sel == 1) addr[p] = 32'hFFFF_FFF0;
            else               addr[p] = $urandom_range(0, 31);
         end
         if ($urandom_range(0, 3) == 0) addr[1] = addr[0];
         step();
      end
      idle();
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
